// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared memory-size encodings and stage state enumeration
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store replication, alignment and load lane extension
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_data,
  output logic        req_aligned,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    req_aligned = 1'b1;
    req_be      = 4'b1111;
    req_wdata   = req_data;
    case (req_size)
      SIZE_BYTE: begin
        req_be    = 4'b0001 << req_lo;
        req_wdata = {4{req_data[7:0]}};
      end
      SIZE_HALF: begin
        req_aligned = !req_lo[0];
        req_be      = req_lo[1] ? 4'b1100 : 4'b0011;
        req_wdata   = {2{req_data[15:0]}};
      end
      default: req_aligned = (req_lo == 2'b00);
    endcase
  end

  always_comb begin
    case (ld_lo)
      2'd0:    byte_lane = ld_rdata[7:0];
      2'd1:    byte_lane = ld_rdata[15:8];
      2'd2:    byte_lane = ld_rdata[23:16];
      default: byte_lane = ld_rdata[31:24];
    endcase
    half_lane = ld_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{ld_signed & byte_lane[7]}}, byte_lane};
      SIZE_HALF: ld_data = {{16{ld_signed & half_lane[15]}}, half_lane};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage: ALU pass-through, data bus access, writeback register
module mem_access_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_address,
  input  logic        load,
  input  logic        store,
  input  logic        write_reg,
  input  logic        load_signed,
  input  logic [1:0]  mem_size,
  input  logic [4:0]  dest,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_write,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  input  logic        wb_ready,
  output logic        misalign_err
);

  state_e      state, state_nxt;
  logic        accept, mem_op, ack_done;
  logic        req_aligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, ld_data;
  logic [1:0]  ld_size, ld_lo;
  logic        ld_signed;
  logic [4:0]  pend_dest;

  assign mem_op   = load | store;
  assign accept   = in_valid & in_ready & !flush;
  assign ack_done = (state == WAIT) & dmem_ack;

  mem_lane_align u_align (
    .req_size    (mem_size),
    .req_lo      (mem_address[1:0]),
    .req_data    (reg_data),
    .req_aligned (req_aligned),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
    .ld_size     (ld_size),
    .ld_lo       (ld_lo),
    .ld_signed   (ld_signed),
    .ld_rdata    (dmem_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept & mem_op & req_aligned) state_nxt = WAIT;
      WAIT:    if (dmem_ack) state_nxt = wb_ready ? IDLE : DONE;
      DONE:    if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) & (!wb_valid | wb_ready);
  end

  // Bus request registers only load on acceptance in IDLE, so they stay stable while dmem_req is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      ld_size    <= '0;
      ld_lo      <= '0;
      ld_signed  <= 1'b0;
      pend_dest  <= '0;
    end else if (accept & mem_op & req_aligned) begin
      dmem_req   <= 1'b1;
      dmem_we    <= store;
      dmem_addr  <= {mem_address[31:2], 2'b00};
      dmem_wdata <= req_wdata;
      dmem_be    <= req_be;
      ld_size    <= mem_size;
      ld_lo      <= mem_address[1:0];
      ld_signed  <= load_signed;
      pend_dest  <= dest;
    end else if (ack_done) begin
      dmem_req   <= 1'b0;
    end
  end

  // Register x0 is never written, whatever the source of the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_write     <= 1'b0;
      wb_data      <= '0;
      wb_dest      <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (ack_done) begin
        wb_valid <= 1'b1;
        wb_write <= !dmem_we & (pend_dest != 5'd0);
        wb_data  <= dmem_we ? 32'd0 : ld_data;
        wb_dest  <= pend_dest;
      end else if (accept & !mem_op) begin
        wb_valid <= 1'b1;
        wb_write <= write_reg & (dest != 5'd0);
        wb_data  <= reg_data;
        wb_dest  <= dest;
      end else if (accept & !req_aligned) begin
        wb_valid     <= 1'b1;
        wb_write     <= 1'b0;
        wb_data      <= 32'd0;
        wb_dest      <= dest;
        misalign_err <= 1'b1;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench: vector table, corner sequences, randomized ops vs model
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] reg_data, mem_address;
  logic        load, store, write_reg, load_signed;
  logic [1:0]  mem_size;
  logic [4:0]  dest;
  logic        flush;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_write, wb_ready, misalign_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .reg_data(reg_data), .mem_address(mem_address), .load(load), .store(store),
    .write_reg(write_reg), .load_signed(load_signed), .mem_size(mem_size), .dest(dest),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_write(wb_write), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_ready(wb_ready), .misalign_err(misalign_err)
  );

  typedef struct {
    logic        ld, st, sgn;
    logic [1:0]  size;
    logic [31:0] addr, data, rdata;
    logic [4:0]  dest;
    logic        wr;
    int          delay, stall;
    logic [31:0] exp_data;
    logic        exp_write, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic ld, logic st, logic sgn, logic [1:0] size, logic [31:0] addr,
                              logic [31:0] data, logic [31:0] rdata, logic [4:0] dst, logic wr,
                              int delay, int stall, logic [31:0] exp_data, logic exp_write,
                              logic exp_mis, logic [3:0] exp_be, logic [31:0] exp_wdata);
    vec_t v;
    v.ld = ld; v.st = st; v.sgn = sgn; v.size = size; v.addr = addr; v.data = data;
    v.rdata = rdata; v.dest = dst; v.wr = wr; v.delay = delay; v.stall = stall;
    v.exp_data = exp_data; v.exp_write = exp_write; v.exp_mis = exp_mis;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Reference model: results from the access rules with plain arithmetic.
  function automatic vec_t ref_vec(vec_t v);
    vec_t r;
    int off;
    logic [31:0] lane;
    r = v;
    off = int'(v.addr % 4);
    r.exp_mis = (v.ld || v.st) && !((v.size == 0) || (v.size == 1 && off % 2 == 0) || (v.size == 2 && off == 0));
    r.exp_be = (v.size == 0) ? 4'(1 << off) : (v.size == 1) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
    r.exp_wdata = (v.size == 0) ? (v.data % 256) * 32'h01010101 :
                  (v.size == 1) ? (v.data % 65536) * 32'h00010001 : v.data;
    if (v.size == 0) begin
      lane = (v.rdata >> (8 * off)) % 256;
      if (v.sgn && lane >= 128) lane = lane - 256;
    end else if (v.size == 1) begin
      lane = (v.rdata >> ((off >= 2) ? 16 : 0)) % 65536;
      if (v.sgn && lane >= 32768) lane = lane - 65536;
    end else begin
      lane = v.rdata;
    end
    r.exp_data = (v.ld || v.st) ? lane : v.data;
    r.exp_write = r.exp_mis ? 1'b0 : v.st ? 1'b0 : v.ld ? (v.dest != 0) : (v.wr && v.dest != 0);
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    logic mem, go;
    mem = v.ld | v.st;
    go  = mem & !v.exp_mis;
    @(negedge clk);
    in_valid = 1'b1; load = v.ld; store = v.st; load_signed = v.sgn; mem_size = v.size;
    mem_address = v.addr; reg_data = v.data; dest = v.dest; write_reg = v.wr;
    wb_ready = (v.stall == 0);
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; load = 1'b0; store = 1'b0;
    mem_address = $urandom; reg_data = $urandom; dest = 5'($urandom);
    if (go) begin
      chk("req_start", dmem_req, 1);
      chk("req_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
      chk("req_be", dmem_be, v.exp_be);
      chk("req_we", dmem_we, v.st);
      if (v.st) chk("req_wdata", dmem_wdata, v.exp_wdata);
      for (int k = 0; k < v.delay; k++) begin
        chk("wait_in_ready", in_ready, 0);
        flush = 1'($urandom_range(0, 1));
        in_valid = flush;
        @(negedge clk);
        chk("req_hold", dmem_req, 1);
        chk("req_addr_hold", dmem_addr, v.addr & 32'hFFFF_FFFC);
        chk("req_be_hold", dmem_be, v.exp_be);
      end
      flush = 1'b0; in_valid = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = v.rdata;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      chk("req_drop", dmem_req, 0);
    end else begin
      chk("no_req", dmem_req, 0);
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_write", wb_write, v.exp_write);
    chk("wb_dest", wb_dest, v.dest);
    chk("misalign", misalign_err, v.exp_mis);
    if (!v.st && !v.exp_mis) chk("wb_data", wb_data, v.exp_data);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk("hold_valid", wb_valid, 1);
      chk("hold_write", wb_write, v.exp_write);
      if (!v.st && !v.exp_mis) chk("hold_data", wb_data, v.exp_data);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_misalign", misalign_err, 0);
      chk("hold_no_req", dmem_req, 0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("wb_clear", wb_valid, 0);
    chk("misalign_clear", misalign_err, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t r;
    int op;
    rst_n = 1'b0; in_valid = 1'b0; reg_data = '0; mem_address = '0; load = 1'b0; store = 1'b0;
    write_reg = 1'b0; load_signed = 1'b0; mem_size = 2'b10; dest = '0; flush = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0; wb_ready = 1'b1;

    tbl[0]  = mk(0,0,0,2'd2, 32'h0,    32'h000000A5, 32'h0,        5'd3, 1, 0,0, 32'h000000A5,1,0, 4'h0,    32'h0);
    tbl[1]  = mk(1,0,1,2'd0, 32'h1003, 32'h0,        32'h80FFFF7F, 5'd5, 1, 3,0, 32'hFFFFFF80,1,0, 4'b1000, 32'h0);
    tbl[2]  = mk(0,1,0,2'd1, 32'h2002, 32'h1234BEEF, 32'h0,        5'd0, 0, 2,0, 32'h0,       0,0, 4'b1100, 32'hBEEFBEEF);
    tbl[3]  = mk(1,0,0,2'd2, 32'h3001, 32'h0,        32'h0,        5'd6, 1, 0,0, 32'h0,       0,1, 4'h0,    32'h0);
    tbl[4]  = mk(0,0,0,2'd0, 32'h0,    32'h00000055, 32'h0,        5'd0, 1, 0,0, 32'h00000055,0,0, 4'h0,    32'h0);
    tbl[5]  = mk(1,0,0,2'd1, 32'h4002, 32'h0,        32'hBEEF1234, 5'd7, 0, 1,2, 32'h0000BEEF,1,0, 4'b1100, 32'h0);
    tbl[6]  = mk(1,0,1,2'd1, 32'h4000, 32'h0,        32'h12348001, 5'd8, 1, 0,0, 32'hFFFF8001,1,0, 4'b0011, 32'h0);
    tbl[7]  = mk(0,1,0,2'd2, 32'h5004, 32'hDEADBEEF, 32'h0,        5'd0, 0, 1,1, 32'h0,       0,0, 4'b1111, 32'hDEADBEEF);
    tbl[8]  = mk(0,1,0,2'd0, 32'h6001, 32'h000000AB, 32'h0,        5'd0, 0, 0,0, 32'h0,       0,0, 4'b0010, 32'hABABABAB);
    tbl[9]  = mk(0,1,0,2'd1, 32'h7003, 32'h00000001, 32'h0,        5'd0, 0, 0,0, 32'h0,       0,1, 4'h0,    32'h0);
    tbl[10] = mk(1,0,0,2'd2, 32'h8000, 32'h0,        32'hCAFEF00D, 5'd31,1, 0,0, 32'hCAFEF00D,1,0, 4'b1111, 32'h0);
    tbl[11] = mk(1,0,0,2'd0, 32'h9002, 32'h0,        32'h00C30000, 5'd10,1, 2,0, 32'h000000C3,1,0, 4'b0100, 32'h0);
    tbl[12] = mk(1,0,0,2'd2, 32'hA000, 32'h0,        32'h00000001, 5'd0, 1, 1,0, 32'h00000001,0,0, 4'b1111, 32'h0);
    tbl[13] = mk(0,0,0,2'd2, 32'h0,    32'h0BADF00D, 32'h0,        5'd9, 1, 0,4, 32'h0BADF00D,1,0, 4'h0,    32'h0);

    repeat (2) @(negedge clk);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_write", wb_write, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_dmem_be", dmem_be, 0);
    chk("rst_misalign", misalign_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 14; i++) run_op(tbl[i]);

    // Flush in IDLE: nothing accepted, no bus request.
    @(negedge clk);
    in_valid = 1'b1; load = 1'b1; mem_size = 2'b10; mem_address = 32'h100; dest = 5'd4; flush = 1'b1;
    chk("flush_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; load = 1'b0; flush = 1'b0;
    chk("flush_no_req", dmem_req, 0);
    chk("flush_no_wb", wb_valid, 0);
    @(negedge clk);
    chk("flush_no_req2", dmem_req, 0);

    // Reset while a load is waiting for its acknowledge.
    in_valid = 1'b1; load = 1'b1; mem_size = 2'b10; mem_address = 32'hB000; dest = 5'd4;
    @(negedge clk);
    in_valid = 1'b0; load = 1'b0;
    chk("rw_req", dmem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rw_req_low", dmem_req, 0);
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_idle", in_ready, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_wb", wb_valid, 0);
    chk("stray_ack_req", dmem_req, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      r.ld = (op == 1); r.st = (op == 2); r.sgn = 1'($urandom_range(0, 1));
      r.size = 2'($urandom_range(0, 2)); r.addr = $urandom; r.data = $urandom; r.rdata = $urandom;
      r.dest = 5'($urandom_range(0, 31)); r.wr = 1'($urandom_range(0, 1));
      r.delay = $urandom_range(0, 3); r.stall = $urandom_range(0, 2);
      run_op(ref_vec(r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1 bit: the upstream stage presents an operation.
REQ-004 SHALL have port in_ready, output, 1 bit: the stage accepts the operation this cycle.
REQ-005 SHALL have ports reg_data, mem_address, input, 32 bits each: ALU result or store data, and the effective address.
REQ-006 SHALL have ports load, store, write_reg, load_signed, input, 1 bit each, plus mem_size, input, 2 bits (00 byte, 01 half, 10 word) and dest, input, 5 bits.
REQ-007 SHALL have port flush, input, 1 bit: branch cancel; drops the operation presented this cycle.
REQ-008 SHALL have ports dmem_req, dmem_we, output, 1 bit; dmem_addr, dmem_wdata, output, 32 bits; dmem_be, output, 4 bits.
REQ-009 SHALL have ports dmem_ack, input, 1 bit, and dmem_rdata, input, 32 bits.
REQ-010 SHALL have ports wb_valid, wb_write, output, 1 bit; wb_data, output, 32 bits; wb_dest, output, 5 bits; wb_ready, input, 1 bit.
REQ-011 SHALL have port misalign_err, output, 1 bit: one-cycle pulse.

Function
REQ-012 SHALL implement the states IDLE, WAIT and DONE.
REQ-013 SHALL drive in_ready = 1 only when the state is IDLE and the output register is free, i.e. !wb_valid or wb_ready.
REQ-014 SHALL accept an operation on in_valid & in_ready & !flush; with flush=1 nothing is accepted and the state is unchanged.
REQ-015 SHALL pass an accepted operation with load=0 and store=0 to the output register on the next edge: wb_data=reg_data, wb_write=write_reg, state stays IDLE; latency 1.
REQ-016 SHALL move an accepted aligned load or store to WAIT and register addr, data, be and we. dmem_req is high from the next cycle until the cycle of dmem_ack inclusive, and all dmem_* outputs stay stable while dmem_req=1.
REQ-017 SHALL align as follows: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
REQ-018 SHALL set dmem_addr = {mem_address[31:2], 2'b00}. dmem_be is 1111 for a word, 0011 or 1100 for a half by addr[1], and a one-hot of addr[1:0] for a byte.
REQ-019 SHALL replicate store data across lanes: byte as {4{d[7:0]}}, half as {2{d[15:0]}}.
REQ-020 SHALL, on dmem_ack in WAIT, register the result in the output register:
- load: wb_data = the selected lane, zero- or sign-extended per load_signed; wb_write=1.
- store: wb_write=0.
- next state is DONE, or IDLE if wb_ready.
REQ-021 SHALL hold wb_valid and all wb_* values while wb_valid & !wb_ready, and clear wb_valid on wb_ready when there is no new result.
REQ-022 SHALL force wb_write=0 whenever wb_dest=0.
REQ-023 SHALL handle a misaligned memory operation as follows:
- no dmem_req is issued;
- the output register loads with wb_write=0 next cycle;
- misalign_err pulses for that cycle.
REQ-024 SHALL ignore flush while in WAIT or DONE: the bus transaction completes and its result is delivered.
REQ-025 SHALL ignore dmem_ack outside WAIT.

Reset
REQ-026 SHALL, with rst_n=0 at an edge, set:
- state to IDLE;
- wb_valid, wb_write, dmem_req, dmem_we, misalign_err to 0;
- wb_data, wb_dest, dmem_addr, dmem_wdata, dmem_be to 0.
REQ-027 SHALL abandon any pending request on a reset during WAIT; dmem_req is low the cycle after reset.

Structure
REQ-028 SHALL take the mem_size encodings and the state enumeration from the shared package mips_pkg.
REQ-029 SHALL place lane selection, byte enables, store replication and load extension in the combinational sub-module mem_lane_align.

Verification
REQ-030 SHALL cover an ALU pass-through: reg_data=0x0000_00A5, write_reg=1, dest=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=0xA5, wb_write=1.
REQ-031 SHALL cover a signed byte load: addr=0x1003, rdata=0x80FF_FF7F, ack after 3 cycles -> dmem_be=1000; wb_data=0xFFFF_FF80 one cycle after ack; in_ready=0 during WAIT.
REQ-032 SHALL cover a half store: addr=0x2002, reg_data=0x1234_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1; after ack wb_write=0.
REQ-033 SHALL cover a misaligned word load: addr=0x3001 -> dmem_req stays 0, misalign_err pulses 1 cycle, wb_write=0.
REQ-034 SHALL cover back-pressure and flush: wb_ready=0 for 4 cycles -> wb_* held and in_ready=0; flush=1 with in_valid=1 in IDLE -> no acceptance, no request.
REQ-035 SHALL cover reset mid-WAIT: rst_n=0 at an edge -> dmem_req=0 and wb_valid=0 next cycle, state IDLE.
